mac_stop_mem_stream: RTL and testbench
======================================

Name: mac_stop_mem_stream

Overview:
- Parametrised successor to the matrix A/B/C store of the MAC-stop datapath.
- Holds A (MxK), B (KxN) and result C (MxN) with registered random-access read/write ports per matrix.
- Adds read-modify-write accumulate on C and a command-driven stream engine. The engine bursts a row of A, a column of B or a row of C out over a valid/ready port, or clears all of C.
- Sits between the host loader and the MAC array; the engine feeds operands and drains results.

Parameters:
- M, 4, rows of A and C
- K, 4, columns of A / rows of B
- N, 4, columns of B and C
- DW, 32, element width of A and B
- RW, 2*DW+$clog2(K), element width of C and of the stream data
- IW, $clog2(max(M,K,N)) (min 1), stream command index width

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock; reset is synchronous and active-high
- a_we, a_re  in  1  A write / read strobes
- a_row  in  $clog2(M)  A row address
- a_col  in  $clog2(K)  A column address
- a_wdata  in  DW  A write data
- a_rdata  out  DW  A registered read data
- b_we, b_re  in  1  B write / read strobes
- b_row  in  $clog2(K)  B row address
- b_col  in  $clog2(N)  B column address
- b_wdata  in  DW  B write data
- b_rdata  out  DW  B registered read data
- c_we, c_acc, c_re  in  1  C write, accumulate qualifier, read strobe
- c_row  in  $clog2(M)  C row address
- c_col  in  $clog2(N)  C column address
- c_wdata  in  RW  C write data
- c_rdata  out  RW  C registered read data
- rd_valid  out  3  per-matrix read-data valid, bit0=A, bit1=B, bit2=C
- cmd_valid  in  1  stream command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=ROW_A, 1=COL_B, 2=ROW_C, 3=CLEAR_C
- cmd_idx  in  IW  row/column index for the command
- s_valid  out  1  stream element valid
- s_ready  in  1  downstream ready
- s_data  out  RW  stream element, A/B zero-extended
- s_last  out  1  final element of a burst
- busy  out  1  engine not IDLE
- err  out  1  one-cycle error pulse

Behaviour:
- Reset: all three matrices cleared to 0; engine to IDLE. All outputs go to 0 (a/b/c_rdata, rd_valid, s_valid, s_data, s_last, busy, err) except cmd_ready, which goes to 1.
- Reset mid-burst or mid-clear aborts the operation. s_valid is 0 the cycle after reset is sampled.
- Random write: takes effect at the edge where *_we is sampled.
- C write with c_acc=1: C[r][c] <= C[r][c] + c_wdata, mod 2^RW, single cycle. With c_acc=0 it is a plain overwrite. c_acc is ignored when c_we=0.
- Random read: *_rdata and rd_valid bit are registered one cycle after *_re. Data holds until the next read of that matrix; the rd_valid bit is a one-cycle pulse.
- Same-address read and write in one cycle: the read returns the old value.
- While busy=1, the engine owns all memories:
  - any random *_we or *_re is ignored (no write, no rd_valid pulse);
  - err pulses the next cycle.
- Command acceptance: at an edge with cmd_valid & cmd_ready.
- Index out of range (ROW_A/ROW_C idx>=M, COL_B idx>=N): command accepted, err pulses, engine stays IDLE, nothing is streamed.
- FSM states: IDLE, STREAM, DRAIN, CLEAR.
  - IDLE -> STREAM on an accepted ROW_A, COL_B or ROW_C.
  - IDLE -> CLEAR on an accepted CLEAR_C.
  - STREAM: a single-entry output register is loaded with element cnt whenever (!s_valid | s_ready); cnt then increments. The first element is valid the cycle after acceptance.
  - Burst lengths: ROW_A = K elements A[idx][0..K-1]; COL_B = K elements B[0..K-1][idx]; ROW_C = N elements C[idx][0..N-1].
  - On loading the last element (s_last=1), STREAM -> DRAIN.
  - DRAIN -> IDLE on s_valid & s_ready. cmd_ready is back to 1 on the following cycle.
  - Throughput is one element per cycle while s_ready=1. s_data and s_last are held stable while s_valid & !s_ready.
  - CLEAR: writes 0 to one C element per cycle in row-major order, M*N cycles, then -> IDLE. s_valid stays 0.
- busy = (state != IDLE).

Decomposition:
- Package mac_stop_mem_pkg holds:
  - cmd_op enum (OP_ROW_A, OP_COL_B, OP_ROW_C, OP_CLEAR_C);
  - FSM state enum;
  - width helper function max3 for IW.
- Single natural sub-module: mac_stop_stream_ctrl, containing the FSM, element counter, output register and err generation. It drives memory read/clear addresses into the top-level arrays.

Test Plan:
- Load A={{4,3,2,5},{3,4,5,2},{5,2,4,3},{2,5,3,4}}, B and C per test case 2; random-read all 48 elements -> each matches, rd_valid pulses one cycle after *_re.
- ROW_A idx=1 with s_ready=1 -> s_data 3,4,5,2 on consecutive cycles; s_last with 2; busy falls and cmd_ready rises the cycle after the handshake.
- COL_B idx=2 with s_ready toggled 1,0,0,1,... -> sequence 5,8,7,6 with no loss or duplication; s_data stable while stalled.
- C[2][3]=95: c_we+c_acc with c_wdata=5 -> read 100. Then C[0][0]=2^RW-1 accumulate 1 -> read 0 (wrap).
- CLEAR_C -> busy for exactly 16 cycles. An a_we issued mid-clear is ignored and err pulses. Afterwards all C reads return 0.
- With M=3: ROW_A idx=3 -> err pulse, no s_valid. Separately, reset asserted during ROW_C -> s_valid=0 next cycle and cmd_ready=1.

Source files
------------

// File: rtl/mac_stop_mem_pkg.sv
// Shared types and width helpers for the MAC-stop matrix store.
// Imported by the stream controller and the store top.
package mac_stop_mem_pkg;

   typedef enum logic [1:0] {
      OP_ROW_A   = 2'd0,
      OP_COL_B   = 2'd1,
      OP_ROW_C   = 2'd2,
      OP_CLEAR_C = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_CLEAR  = 2'd3
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int clog2m1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/mac_stop_stream_ctrl.sv
// Stream engine: command FSM, element counter, single-entry output
// register, C clear sequencer and error pulse generation.
module mac_stop_stream_ctrl
   import mac_stop_mem_pkg::*;
#(
   parameter int M  = 4,
   parameter int K  = 4,
   parameter int N  = 4,
   parameter int RW = 66,
   parameter int IW = 2,
   parameter int MA = 2,
   parameter int NA = 2,
   parameter int CW = 3
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic [1:0]    cmd_op_i,
   input  logic [IW-1:0] cmd_idx_i,
   output logic          s_valid_o,
   input  logic          s_ready_i,
   output logic [RW-1:0] s_data_o,
   output logic          s_last_o,
   output logic          busy_o,
   output logic          err_o,
   input  logic          mem_req_i,
   output cmd_op_e       rd_op_o,
   output logic [IW-1:0] rd_idx_o,
   output logic [CW-1:0] rd_cnt_o,
   input  logic [RW-1:0] elem_i,
   output logic          clr_we_o,
   output logic [MA-1:0] clr_row_o,
   output logic [NA-1:0] clr_col_o
);

   localparam logic [CW-1:0] KL = CW'(K - 1);
   localparam logic [CW-1:0] NL = CW'(N - 1);

   state_e        state_q;
   cmd_op_e       op_q;
   logic [IW-1:0] idx_q;
   logic [CW-1:0] cnt_q;
   logic          sv_q;
   logic          sl_q;
   logic          err_q;
   logic [RW-1:0] sd_q;
   logic [MA-1:0] cr_q;
   logic [NA-1:0] cc_q;

   cmd_op_e cop;
   logic    idle;
   logic    accept;
   logic    in_range;
   logic    strm_op;
   logic    is_last;
   logic    load;

   // In IDLE the read port follows the command so element 0 loads on accept
   always_comb begin
      idle     = (state_q == ST_IDLE);
      cop      = cmd_op_e'(cmd_op_i);
      accept   = cmd_valid_i & idle;
      rd_op_o  = idle ? cop : op_q;
      rd_idx_o = idle ? cmd_idx_i : idx_q;
      rd_cnt_o = idle ? '0 : cnt_q;
      in_range = 1'b1;
      unique case (1'b1)
         (cop == OP_ROW_A): in_range = int'(cmd_idx_i) < M;
         (cop == OP_ROW_C): in_range = int'(cmd_idx_i) < M;
         (cop == OP_COL_B): in_range = int'(cmd_idx_i) < N;
         default:           in_range = 1'b1;
      endcase
      strm_op = (cop != OP_CLEAR_C);
      is_last = (rd_op_o == OP_ROW_C) ? (rd_cnt_o == NL)
                                      : (rd_cnt_o == KL);
      load = (accept & strm_op & in_range)
           | ((state_q == ST_STREAM) & (!sv_q | s_ready_i));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         op_q    <= OP_ROW_A;
         idx_q   <= '0;
         cnt_q   <= '0;
         sv_q    <= 1'b0;
         sl_q    <= 1'b0;
         sd_q    <= '0;
         err_q   <= 1'b0;
         cr_q    <= '0;
         cc_q    <= '0;
      end else begin
         err_q <= (!idle & mem_req_i) | (accept & !in_range);
         if (load) begin
            sv_q  <= 1'b1;
            sd_q  <= elem_i;
            sl_q  <= is_last;
            cnt_q <= rd_cnt_o + CW'(1);
         end
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q  <= cop;
                  idx_q <= cmd_idx_i;
                  cr_q  <= '0;
                  cc_q  <= '0;
                  if (!strm_op) begin
                     state_q <= ST_CLEAR;
                  end else if (in_range) begin
                     state_q <= is_last ? ST_DRAIN : ST_STREAM;
                  end
               end
            end
            ST_STREAM: begin
               if (load && is_last) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (sv_q && s_ready_i) begin
                  sv_q    <= 1'b0;
                  sl_q    <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_CLEAR: begin
               if (cc_q == NA'(N - 1)) begin
                  cc_q <= '0;
                  cr_q <= cr_q + MA'(1);
                  if (cr_q == MA'(M - 1)) state_q <= ST_IDLE;
               end else begin
                  cc_q <= cc_q + NA'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready_o = idle;
   assign busy_o      = !idle;
   assign s_valid_o   = sv_q;
   assign s_data_o    = sd_q;
   assign s_last_o    = sl_q;
   assign err_o       = err_q;
   assign clr_we_o    = (state_q == ST_CLEAR);
   assign clr_row_o   = cr_q;
   assign clr_col_o   = cc_q;

endmodule

// File: rtl/mac_stop_mem_stream.sv
// A/B/C matrix store with registered random access, C accumulate and
// a stream engine that owns the arrays while busy.
module mac_stop_mem_stream
   import mac_stop_mem_pkg::*;
#(
   parameter int M  = 4,
   parameter int K  = 4,
   parameter int N  = 4,
   parameter int DW = 32,
   parameter int RW = 2 * DW + $clog2(K),
   parameter int IW = clog2m1(max3(M, K, N))
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_we,
   input  logic                  a_re,
   input  logic [clog2m1(M)-1:0] a_row,
   input  logic [clog2m1(K)-1:0] a_col,
   input  logic [DW-1:0]         a_wdata,
   output logic [DW-1:0]         a_rdata,
   input  logic                  b_we,
   input  logic                  b_re,
   input  logic [clog2m1(K)-1:0] b_row,
   input  logic [clog2m1(N)-1:0] b_col,
   input  logic [DW-1:0]         b_wdata,
   output logic [DW-1:0]         b_rdata,
   input  logic                  c_we,
   input  logic                  c_acc,
   input  logic                  c_re,
   input  logic [clog2m1(M)-1:0] c_row,
   input  logic [clog2m1(N)-1:0] c_col,
   input  logic [RW-1:0]         c_wdata,
   output logic [RW-1:0]         c_rdata,
   output logic [2:0]            rd_valid,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [IW-1:0]         cmd_idx,
   output logic                  s_valid,
   input  logic                  s_ready,
   output logic [RW-1:0]         s_data,
   output logic                  s_last,
   output logic                  busy,
   output logic                  err
);

   localparam int MA = clog2m1(M);
   localparam int KA = clog2m1(K);
   localparam int NA = clog2m1(N);
   localparam int CW = $clog2(max3(K, N, 1) + 1);

   logic [DW-1:0] a_q [M][K];
   logic [DW-1:0] b_q [K][N];
   logic [RW-1:0] c_q [M][N];
   logic [DW-1:0] a_rdata_q;
   logic [DW-1:0] b_rdata_q;
   logic [RW-1:0] c_rdata_q;
   logic [2:0]    rd_valid_q;

   cmd_op_e       rd_op;
   logic [IW-1:0] rd_idx;
   logic [CW-1:0] rd_cnt;
   logic [RW-1:0] elem;
   logic          clr_we;
   logic [MA-1:0] clr_row;
   logic [NA-1:0] clr_col;
   logic          free;
   logic          mem_req;

   assign free    = !busy;
   assign mem_req = a_we | a_re | b_we | b_re | c_we | c_re;

   always_comb begin
      elem = '0;
      case (rd_op)
         OP_ROW_A: elem = RW'(a_q[rd_idx[MA-1:0]][rd_cnt[KA-1:0]]);
         OP_COL_B: elem = RW'(b_q[rd_cnt[KA-1:0]][rd_idx[NA-1:0]]);
         OP_ROW_C: elem = c_q[rd_idx[MA-1:0]][rd_cnt[NA-1:0]];
         default:  elem = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < M; r++)
            for (int c = 0; c < K; c++) a_q[r][c] <= '0;
         a_rdata_q <= '0;
      end else begin
         if (a_we & free) a_q[a_row][a_col] <= a_wdata;
         if (a_re & free) a_rdata_q <= a_q[a_row][a_col];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < N; c++) b_q[r][c] <= '0;
         b_rdata_q <= '0;
      end else begin
         if (b_we & free) b_q[b_row][b_col] <= b_wdata;
         if (b_re & free) b_rdata_q <= b_q[b_row][b_col];
      end
   end

   // Clear and host writes never collide: host writes are dropped while busy
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) c_q[r][c] <= '0;
         c_rdata_q <= '0;
      end else begin
         if (clr_we) begin
            c_q[clr_row][clr_col] <= '0;
         end else if (c_we & free) begin
            c_q[c_row][c_col] <= c_acc ? c_q[c_row][c_col] + c_wdata
                                       : c_wdata;
         end
         if (c_re & free) c_rdata_q <= c_q[c_row][c_col];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_q <= '0;
      end else begin
         rd_valid_q <= {c_re & free, b_re & free, a_re & free};
      end
   end

   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;
   assign c_rdata  = c_rdata_q;
   assign rd_valid = rd_valid_q;

   mac_stop_stream_ctrl #(
      .M  (M),
      .K  (K),
      .N  (N),
      .RW (RW),
      .IW (IW),
      .MA (MA),
      .NA (NA),
      .CW (CW)
   ) u_ctrl (
      .clk_i       (clk),
      .reset_i     (reset),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_op_i    (cmd_op),
      .cmd_idx_i   (cmd_idx),
      .s_valid_o   (s_valid),
      .s_ready_i   (s_ready),
      .s_data_o    (s_data),
      .s_last_o    (s_last),
      .busy_o      (busy),
      .err_o       (err),
      .mem_req_i   (mem_req),
      .rd_op_o     (rd_op),
      .rd_idx_o    (rd_idx),
      .rd_cnt_o    (rd_cnt),
      .elem_i      (elem),
      .clr_we_o    (clr_we),
      .clr_row_o   (clr_row),
      .clr_col_o   (clr_col)
   );

endmodule

// File: tb/tb_mac_stop_mem_stream.sv
// Directed bench for the matrix store: 4x4x4 instance plus an M=3
// instance for the out-of-range command case.
module tb_mac_stop_mem_stream;

   localparam int RW = 66;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_we, a_re, b_we, b_re, c_we, c_acc, c_re;
   logic [1:0]    a_row, a_col, b_row, b_col, c_row, c_col;
   logic [31:0]   a_wdata, a_rdata, b_wdata, b_rdata;
   logic [RW-1:0] c_wdata, c_rdata, s_data;
   logic [2:0]    rd_valid;
   logic          cmd_valid, cmd_ready, s_valid, s_ready, s_last;
   logic          busy, err;
   logic [1:0]    cmd_op, cmd_idx;

   logic          m3_a_rs, m3_cmd_valid, m3_cmd_ready, m3_s_valid;
   logic          m3_s_last, m3_busy, m3_err;
   logic [1:0]    m3_addr, m3_cmd_op, m3_cmd_idx;
   logic [31:0]   m3_wd, m3_a_rdata, m3_b_rdata;
   logic [RW-1:0] m3_cwd, m3_c_rdata, m3_s_data;
   logic [2:0]    m3_rd_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_stop_mem_stream u_dut (
      .clk(clk), .reset(reset),
      .a_we(a_we), .a_re(a_re), .a_row(a_row), .a_col(a_col),
      .a_wdata(a_wdata), .a_rdata(a_rdata),
      .b_we(b_we), .b_re(b_re), .b_row(b_row), .b_col(b_col),
      .b_wdata(b_wdata), .b_rdata(b_rdata),
      .c_we(c_we), .c_acc(c_acc), .c_re(c_re), .c_row(c_row),
      .c_col(c_col), .c_wdata(c_wdata), .c_rdata(c_rdata),
      .rd_valid(rd_valid),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_idx(cmd_idx), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .busy(busy), .err(err)
   );

   mac_stop_mem_stream #(.M(3)) u_m3 (
      .clk(clk), .reset(reset),
      .a_we(m3_a_rs), .a_re(m3_a_rs), .a_row(m3_addr), .a_col(m3_addr),
      .a_wdata(m3_wd), .a_rdata(m3_a_rdata),
      .b_we(m3_a_rs), .b_re(m3_a_rs), .b_row(m3_addr), .b_col(m3_addr),
      .b_wdata(m3_wd), .b_rdata(m3_b_rdata),
      .c_we(m3_a_rs), .c_acc(m3_a_rs), .c_re(m3_a_rs), .c_row(m3_addr),
      .c_col(m3_addr), .c_wdata(m3_cwd), .c_rdata(m3_c_rdata),
      .rd_valid(m3_rd_valid),
      .cmd_valid(m3_cmd_valid), .cmd_ready(m3_cmd_ready),
      .cmd_op(m3_cmd_op), .cmd_idx(m3_cmd_idx),
      .s_valid(m3_s_valid), .s_ready(1'b1),
      .s_data(m3_s_data), .s_last(m3_s_last),
      .busy(m3_busy), .err(m3_err)
   );

   typedef struct {
      int            mat;
      int            row;
      int            col;
      logic [RW-1:0] exp;
   } rd_vec_t;

   rd_vec_t vecs[48];

   int ra[4][4] = '{'{4, 3, 2, 5}, '{3, 4, 5, 2},
                    '{5, 2, 4, 3}, '{2, 5, 3, 4}};
   int rb[4][4] = '{'{1, 2, 5, 3}, '{4, 6, 8, 2},
                    '{9, 1, 7, 4}, '{3, 5, 6, 8}};
   int rc[4][4] = '{'{10, 11, 12, 13}, '{20, 21, 22, 23},
                    '{30, 31, 32, 95}, '{40, 41, 42, 43}};
   int rowa_exp[4] = '{3, 4, 5, 2};
   int colb_exp[4] = '{5, 8, 7, 6};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [RW-1:0] act,
                      input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
      end
   endtask

   task automatic do_write(input int mat, input int r, input int c,
                           input logic [RW-1:0] val, input logic acc);
      case (mat)
         0: begin a_we = 1'b1; a_row = 2'(r); a_col = 2'(c); a_wdata = val[31:0]; end
         1: begin b_we = 1'b1; b_row = 2'(r); b_col = 2'(c); b_wdata = val[31:0]; end
         default: begin
            c_we = 1'b1; c_acc = acc; c_row = 2'(r); c_col = 2'(c); c_wdata = val;
         end
      endcase
      tick();
      a_we = 1'b0; b_we = 1'b0; c_we = 1'b0; c_acc = 1'b0;
   endtask

   task automatic do_read(input int mat, input int r, input int c,
                          output logic [RW-1:0] d);
      case (mat)
         0: begin a_re = 1'b1; a_row = 2'(r); a_col = 2'(c); end
         1: begin b_re = 1'b1; b_row = 2'(r); b_col = 2'(c); end
         default: begin c_re = 1'b1; c_row = 2'(r); c_col = 2'(c); end
      endcase
      tick();
      a_re = 1'b0; b_re = 1'b0; c_re = 1'b0;
      case (mat)
         0: d = RW'(a_rdata);
         1: d = RW'(b_rdata);
         default: d = c_rdata;
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [RW-1:0] d;
      logic [RW-1:0] prev_d;
      logic          prev_stall;
      int            n;
      int            cyc;

      reset = 1'b1;
      {a_we, a_re, b_we, b_re, c_we, c_acc, c_re} = '0;
      {a_row, a_col, b_row, b_col, c_row, c_col} = '0;
      a_wdata = '0; b_wdata = '0; c_wdata = '0;
      cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; s_ready = 1'b1;
      m3_a_rs = 1'b0; m3_addr = '0; m3_wd = '0; m3_cwd = '0;
      m3_cmd_valid = 1'b0; m3_cmd_op = '0; m3_cmd_idx = '0;

      for (int m = 0; m < 3; m++)
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               vecs[m*16 + r*4 + c].mat = m;
               vecs[m*16 + r*4 + c].row = r;
               vecs[m*16 + r*4 + c].col = c;
               vecs[m*16 + r*4 + c].exp =
                  RW'((m == 0) ? ra[r][c] : (m == 1) ? rb[r][c] : rc[r][c]);
            end

      tick(); tick();
      chk("rst_a_rdata", RW'(a_rdata), '0);
      chk("rst_rd_valid", RW'(rd_valid), '0);
      chkb("rst_s_valid", s_valid, 1'b0);
      chkb("rst_cmd_ready", cmd_ready, 1'b1);
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_err", err, 1'b0);
      reset = 1'b0;
      do_read(2, 1, 1, d);
      chk("rst_c_cleared", d, '0);
      tick();

      foreach (vecs[i]) do_write(vecs[i].mat, vecs[i].row, vecs[i].col,
                                 vecs[i].exp, 1'b0);

      foreach (vecs[i]) begin
         do_read(vecs[i].mat, vecs[i].row, vecs[i].col, d);
         chk("rd_data", d, vecs[i].exp);
         chk("rd_valid", RW'(rd_valid), RW'(3'b001 << vecs[i].mat));
      end
      tick();
      chk("rd_valid_pulse", RW'(rd_valid), '0);

      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_idx = 2'd1; s_ready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chkb("rowa_cmd_ready_low", cmd_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chkb("rowa_valid", s_valid, 1'b1);
         chk("rowa_data", s_data, RW'(rowa_exp[i]));
         chkb("rowa_last", s_last, i == 3);
         chkb("rowa_busy", busy, 1'b1);
         tick();
      end
      chkb("rowa_end_valid", s_valid, 1'b0);
      chkb("rowa_end_busy", busy, 1'b0);
      chkb("rowa_end_ready", cmd_ready, 1'b1);

      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_idx = 2'd2;
      tick();
      cmd_valid = 1'b0;
      n = 0; prev_stall = 1'b0; prev_d = '0;
      for (int i = 0; i < 20 && n < 4; i++) begin
         s_ready = (i % 3 == 0);
         chkb("colb_valid", s_valid, 1'b1);
         if (prev_stall) chk("colb_hold", s_data, prev_d);
         if (s_valid && s_ready) begin
            chk("colb_data", s_data, RW'(colb_exp[n]));
            chkb("colb_last", s_last, n == 3);
            n++;
         end
         prev_stall = s_valid && !s_ready;
         prev_d = s_data;
         tick();
      end
      s_ready = 1'b1;
      chk("colb_count", RW'(n), RW'(4));
      chkb("colb_end_busy", busy, 1'b0);
      chkb("colb_end_valid", s_valid, 1'b0);

      do_write(2, 2, 3, RW'(5), 1'b1);
      do_read(2, 2, 3, d);
      chk("acc_95_plus_5", d, RW'(100));
      do_write(2, 0, 0, {RW{1'b1}}, 1'b0);
      do_write(2, 0, 0, RW'(1), 1'b1);
      do_read(2, 0, 0, d);
      chk("acc_wrap", d, '0);

      a_we = 1'b1; a_re = 1'b1; a_row = 2'd0; a_col = 2'd0; a_wdata = 32'd77;
      tick();
      a_we = 1'b0; a_re = 1'b0;
      chk("raw_old_value", RW'(a_rdata), RW'(4));
      do_read(0, 0, 0, d);
      chk("raw_new_value", d, RW'(77));

      cmd_valid = 1'b1; cmd_op = 2'd3; cmd_idx = 2'd0;
      tick();
      cmd_valid = 1'b0;
      cyc = 0;
      while (busy && cyc < 40) begin
         a_we = (cyc == 5); a_re = (cyc == 5);
         a_row = 2'd0; a_col = 2'd0; a_wdata = 32'd99;
         tick();
         cyc++;
         if (cyc == 6) begin
            chkb("clr_err_pulse", err, 1'b1);
            chk("clr_no_rd_valid", RW'(rd_valid), '0);
         end
      end
      a_we = 1'b0; a_re = 1'b0;
      chk("clr_busy_cycles", RW'(cyc), RW'(16));
      chkb("clr_err_gone", err, 1'b0);
      do_read(0, 0, 0, d);
      chk("clr_a_untouched", d, RW'(77));
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            do_read(2, r, c, d);
            chk("clr_c_zero", d, '0);
         end

      m3_cmd_valid = 1'b1; m3_cmd_op = 2'd0; m3_cmd_idx = 2'd3;
      tick();
      m3_cmd_valid = 1'b0;
      chkb("m3_oor_err", m3_err, 1'b1);
      chkb("m3_oor_s_valid", m3_s_valid, 1'b0);
      chkb("m3_oor_busy", m3_busy, 1'b0);
      chkb("m3_oor_ready", m3_cmd_ready, 1'b1);
      tick();
      chkb("m3_err_pulse_end", m3_err, 1'b0);
      chkb("m3_no_stream", m3_s_valid, 1'b0);

      do_write(2, 2, 0, RW'(77), 1'b0);
      s_ready = 1'b0;
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_idx = 2'd2;
      tick();
      cmd_valid = 1'b0;
      chkb("rowc_valid", s_valid, 1'b1);
      chk("rowc_data", s_data, RW'(77));
      tick();
      chk("rowc_stall_hold", s_data, RW'(77));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chkb("rstmid_s_valid", s_valid, 1'b0);
      chkb("rstmid_cmd_ready", cmd_ready, 1'b1);
      chkb("rstmid_busy", busy, 1'b0);
      chk("rstmid_s_data", s_data, '0);
      s_ready = 1'b1;
      do_read(2, 2, 0, d);
      chk("rstmid_c_cleared", d, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
